// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared select codes, FSM states and stage-tracker type for the forwarding controller
package fwd_pkg;

   // Widest register index a tracker can hold; narrower indices are zero-extended
   localparam int unsigned FWD_RD_W = 8;

   typedef enum logic [1:0] {
      SEL_RF    = 2'b00,
      SEL_EXMEM = 2'b01,
      SEL_MEMWB = 2'b10,
      SEL_WBBYP = 2'b11
   } fwd_sel_t;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_BUSY = 1'b1
   } fwd_state_t;

   typedef struct packed {
      logic                valid;
      logic [FWD_RD_W-1:0] rd;
      logic                reg_write;
      logic                mem_read;
   } fwd_trk_t;

   localparam fwd_trk_t TRK_EMPTY = '0;

   function automatic logic trk_hit(input fwd_trk_t t, input logic [FWD_RD_W-1:0] rs);
      return t.valid && t.reg_write && (t.rd == rs) && (rs != '0);
   endfunction

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - per-operand youngest-first forwarding match and load-use detect
// FWD_WB_BYPASS_EN: when defined, a WB-stage match selects the write-back bypass (11).
module fwd_match
   import fwd_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  use_i,
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  fwd_trk_t              ex_i,
   input  fwd_trk_t              mem_i,
   input  fwd_trk_t              wb_i,
   output logic [1:0]            sel_o,
   output logic                  load_use_o
);

   logic [FWD_RD_W-1:0] rs_ext;
   logic                hit_ex;
   logic                hit_mem;
   logic                hit_wb;
   fwd_sel_t            sel;

   assign rs_ext  = FWD_RD_W'(rs_i);
   assign hit_ex  = use_i && trk_hit(ex_i, rs_ext);
   assign hit_mem = use_i && trk_hit(mem_i, rs_ext);
   assign hit_wb  = use_i && trk_hit(wb_i, rs_ext);

   always_comb begin
      sel = SEL_RF;
      if (hit_ex) begin
         sel = SEL_EXMEM;
      end else if (hit_mem) begin
         sel = SEL_MEMWB;
      end else if (hit_wb) begin
`ifdef FWD_WB_BYPASS_EN
         sel = SEL_WBBYP;
`else
         // Register file writes before it reads, so the WB value is already visible
         sel = SEL_RF;
`endif
      end
   end

   assign sel_o      = sel;
   assign load_use_o = hit_ex && ex_i.mem_read;

endmodule

// File: rtl/fwd_select_ctrl.sv
// rtl/fwd_select_ctrl.sv - EX operand-mux select generation, load-use stall and multi-cycle load freeze
// WB bypass code depends on FWD_WB_BYPASS_EN (see fwd_match).
module fwd_select_ctrl
   import fwd_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned MEM_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   output logic [1:0]            sel_a,
   output logic [1:0]            sel_b,
   output logic                  stall,
   output logic                  bubble,
   output logic                  busy
);

   localparam logic [0:0]       ST_RUN   = RUN;
   localparam logic [0:0]       ST_BUSY  = MEM_BUSY;
   localparam int unsigned      CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 1) : 0);

   fwd_trk_t         ex_q, ex_d;
   fwd_trk_t         mem_q, mem_d;
   fwd_trk_t         wb_q, wb_d;
   logic [1:0]       sel_a_q, sel_a_d;
   logic [1:0]       sel_b_q, sel_b_d;
   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0] code_a;
   logic [1:0] code_b;
   logic       lu_a;
   logic       lu_b;
   logic       freeze;
   logic       load_use;
   logic       issue;
   fwd_trk_t   id_trk;

   fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_a (
      .use_i      (id_use_rs1),
      .rs_i       (id_rs1),
      .ex_i       (ex_q),
      .mem_i      (mem_q),
      .wb_i       (wb_q),
      .sel_o      (code_a),
      .load_use_o (lu_a)
   );

   fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_b (
      .use_i      (id_use_rs2),
      .rs_i       (id_rs2),
      .ex_i       (ex_q),
      .mem_i      (mem_q),
      .wb_i       (wb_q),
      .sel_o      (code_b),
      .load_use_o (lu_b)
   );

   // A pending load-use retry is swallowed by an active freeze: no bubble then
   assign freeze   = (state_q == ST_BUSY);
   assign load_use = id_valid && (lu_a || lu_b);
   assign stall    = freeze || load_use;
   assign bubble   = load_use && !freeze;
   assign issue    = id_valid && !stall;

   always_comb begin
      id_trk           = TRK_EMPTY;
      id_trk.valid     = 1'b1;
      id_trk.rd        = FWD_RD_W'(id_rd);
      id_trk.reg_write = id_reg_write;
      id_trk.mem_read  = id_mem_read;
   end

   always_comb begin
      ex_d    = ex_q;
      mem_d   = mem_q;
      wb_d    = wb_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (freeze) begin
         if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end else begin
         mem_d = ex_q;
         wb_d  = mem_q;
         if (issue) begin
            ex_d    = id_trk;
            sel_a_d = code_a;
            sel_b_d = code_b;
         end else begin
            ex_d    = TRK_EMPTY;
            sel_a_d = SEL_RF;
            sel_b_d = SEL_RF;
         end
         // The freeze starts on the same edge the load moves into MEM
         if ((MEM_LAT > 1) && ex_q.valid && ex_q.mem_read) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q    <= TRK_EMPTY;
         mem_q   <= TRK_EMPTY;
         wb_q    <= TRK_EMPTY;
         sel_a_q <= SEL_RF;
         sel_b_q <= SEL_RF;
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sel_a = sel_a_q;
   assign sel_b = sel_b_q;
   assign busy  = freeze;

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// tb/tb_fwd_select_ctrl.sv - directed bench for fwd_select_ctrl (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_fwd_select_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
   logic [1:0] sel_a, sel_b, sel_a3, sel_b3;
   logic       stall, bubble, busy, stall3, bubble3, busy3;

   int n_vec = 0;
   int n_err = 0;

`ifdef FWD_WB_BYPASS_EN
   localparam logic [1:0] EXP_WB = 2'b11;
`else
   localparam logic [1:0] EXP_WB = 2'b00;
`endif

   always #5 clk = ~clk;

   fwd_select_ctrl #(.REG_ADDR_W(5), .MEM_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .bubble(bubble), .busy(busy)
   );

   fwd_select_ctrl #(.REG_ADDR_W(5), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .sel_a(sel_a3), .sel_b(sel_b3), .stall(stall3), .bubble(bubble3), .busy(busy3)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic rw, input logic mr);
      id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
      id_rd = rd; id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic idle;
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic apply_reset;
      idle();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      idle();
      rst_n = 1'b0;
      #2;
      n_vec++; if (sel_a !== 2'b00) begin n_err++; $display("FAIL reset_sel_a got=%b exp=00", sel_a); end
      n_vec++; if (sel_b !== 2'b00) begin n_err++; $display("FAIL reset_sel_b got=%b exp=00", sel_b); end
      n_vec++; if (stall !== 1'b0 || bubble !== 1'b0) begin n_err++; $display("FAIL reset_stall_bubble got=%b%b exp=00", stall, bubble); end
      n_vec++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy3); end
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_independent;
      apply_reset();
      set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);
      #1;
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL indep_stall got=%b exp=0", stall); end
      step();
      n_vec++; if (sel_a !== 2'b00 || sel_b !== 2'b00) begin n_err++; $display("FAIL indep_sel got=%b/%b exp=00/00", sel_a, sel_b); end
      idle();
   endtask

   task automatic test_back_to_back;
      apply_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add r5
      step();
      set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);   // sub r8 <- r5
      #1;
      n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall got=%b exp=0", stall); end
      step();
      n_vec++; if (sel_a !== 2'b01) begin n_err++; $display("FAIL b2b_ex_sel_a got=%b exp=01", sel_a); end
      n_vec++; if (sel_b !== 2'b00) begin n_err++; $display("FAIL b2b_ex_sel_b got=%b exp=00", sel_b); end
      set_id(1'b1, 5'd5, 1'b1, 5'd7, 1'b0, 5'd9, 1'b1, 1'b0);
      step();
      n_vec++; if (sel_a !== 2'b10) begin n_err++; $display("FAIL b2b_mem_sel_a got=%b exp=10", sel_a); end
      set_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);
      step();
      n_vec++; if (sel_b !== EXP_WB) begin n_err++; $display("FAIL b2b_wb_sel_b got=%b exp=%b", sel_b, EXP_WB); end
      n_vec++; if (sel_a !== 2'b00) begin n_err++; $display("FAIL b2b_wb_sel_a got=%b exp=00", sel_a); end
      idle();
      step();
      n_vec++; if (sel_b !== 2'b00) begin n_err++; $display("FAIL b2b_noissue_sel_b got=%b exp=00", sel_b); end
   endtask

   task automatic test_priority;
      apply_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
      step();
      n_vec++; if (sel_a !== 2'b01 || sel_b !== 2'b01) begin n_err++; $display("FAIL prio_youngest got=%b/%b exp=01/01", sel_a, sel_b); end
      idle();
   endtask

   task automatic test_r0;
      apply_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);   // writes r0
      step();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0);
      step();
      n_vec++; if (sel_a !== 2'b00 || sel_b !== 2'b00) begin n_err++; $display("FAIL r0_sel got=%b/%b exp=00/00", sel_a, sel_b); end
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd13, 1'b0, 5'd13, 1'b1, 5'd14, 1'b1, 1'b0); // rs1 not actually read
      step();
      n_vec++; if (sel_a !== 2'b00 || sel_b !== 2'b01) begin n_err++; $display("FAIL use_flag_sel got=%b/%b exp=00/01", sel_a, sel_b); end
      idle();
   endtask

   task automatic test_load_use;
      apply_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw r7
      step();
      set_id(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd14, 1'b1, 1'b0);  // add <- r7
      #1;
      n_vec++; if (stall !== 1'b1 || bubble !== 1'b1) begin n_err++; $display("FAIL lu_hazard got=%b%b exp=11", stall, bubble); end
      step();
      n_vec++; if (stall !== 1'b0 || bubble !== 1'b0) begin n_err++; $display("FAIL lu_retry_stall got=%b%b exp=00", stall, bubble); end
      n_vec++; if (sel_a !== 2'b00 || sel_b !== 2'b00) begin n_err++; $display("FAIL lu_bubble_sel got=%b/%b exp=00/00", sel_a, sel_b); end
      step();
      n_vec++; if (sel_b !== 2'b10 || sel_a !== 2'b00) begin n_err++; $display("FAIL lu_issue_sel got=%b/%b exp=00/10", sel_a, sel_b); end
      idle();
   endtask

   task automatic test_freeze;
      apply_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);   // p r4
      step();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw r7
      step();
      set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);   // add r9 <- r4
      #1;
      n_vec++; if (stall3 !== 1'b0) begin n_err++; $display("FAIL frz_pre_stall got=%b exp=0", stall3); end
      step();
      set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);  // q <- r9
      #1;
      n_vec++; if (busy3 !== 1'b1 || stall3 !== 1'b1 || bubble3 !== 1'b0) begin n_err++; $display("FAIL frz_c1_ctl got=%b%b%b exp=110", busy3, stall3, bubble3); end
      n_vec++; if (sel_a3 !== 2'b10) begin n_err++; $display("FAIL frz_c1_sel_a got=%b exp=10", sel_a3); end
      step();
      n_vec++; if (busy3 !== 1'b1 || stall3 !== 1'b1 || sel_a3 !== 2'b10) begin n_err++; $display("FAIL frz_c2 got=%b%b/%b exp=11/10", busy3, stall3, sel_a3); end
      step();
      n_vec++; if (busy3 !== 1'b0 || stall3 !== 1'b0) begin n_err++; $display("FAIL frz_end got=%b%b exp=00", busy3, stall3); end
      step();
      n_vec++; if (sel_a3 !== 2'b01 || busy3 !== 1'b0) begin n_err++; $display("FAIL frz_resume got=%b/%b exp=01/0", sel_a3, busy3); end
      idle();
   endtask

   task automatic test_freeze_vs_load_use;
      apply_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw r7
      step();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);   // lw r8
      step();
      set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);  // add <- r8
      #1;
      n_vec++; if (busy3 !== 1'b1 || stall3 !== 1'b1 || bubble3 !== 1'b0) begin n_err++; $display("FAIL frz_wins got=%b%b%b exp=110", busy3, stall3, bubble3); end
      step();
      step();
      n_vec++; if (busy3 !== 1'b0 || stall3 !== 1'b1 || bubble3 !== 1'b1) begin n_err++; $display("FAIL frz_then_lu got=%b%b%b exp=011", busy3, stall3, bubble3); end
      idle();
   endtask

   task automatic test_reset_mid_freeze;
      apply_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      step();
      idle();
      #1;
      n_vec++; if (busy3 !== 1'b1 || sel_a3 !== 2'b10) begin n_err++; $display("FAIL rmf_pre got=%b/%b exp=1/10", busy3, sel_a3); end
      rst_n = 1'b0;
      #1;
      n_vec++; if (busy3 !== 1'b0 || sel_a3 !== 2'b00 || sel_b3 !== 2'b00 || stall3 !== 1'b0) begin n_err++; $display("FAIL rmf_clear got=%b/%b/%b/%b exp=0/00/00/0", busy3, sel_a3, sel_b3, stall3); end
      step();
      rst_n = 1'b1;
      #1;
      set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0);
      #1;
      n_vec++; if (stall3 !== 1'b0) begin n_err++; $display("FAIL rmf_post_stall got=%b exp=0", stall3); end
      step();
      set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      step();
      n_vec++; if (sel_a3 !== 2'b01 || busy3 !== 1'b0) begin n_err++; $display("FAIL rmf_post_sel got=%b/%b exp=01/0", sel_a3, busy3); end
      idle();
   endtask

   initial begin
      rst_n = 1'b1;
      idle();
      test_reset();
      test_independent();
      test_back_to_back();
      test_priority();
      test_r0();
      test_load_use();
      test_freeze();
      test_freeze_vs_load_use();
      test_reset_mid_freeze();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
